// File: rtl/apb_mac_master_if.sv
// apb_mac_master_if: command/response and APB3 signals between the requester and its environment
interface apb_mac_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   logic                  rsp_timeout;
   logic                  busy;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PSELx;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic                  PREADY;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PSLVERR;
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PRDATA, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
             PADDR, PSELx, PENABLE, PWRITE, PWDATA
   );
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PRDATA, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
             PADDR, PSELx, PENABLE, PWRITE, PWDATA
   );
endinterface

// File: rtl/apb_mac_master.sv
// apb_mac_master: valid/ready command to APB3 transfer requester with wait-state timeout
module apb_mac_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   apb_mac_master_if.master  bus
);
   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] SETUP  = 2'b01;
   localparam logic [1:0] ACCESS = 2'b10;
   localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
   localparam bit TEN = TIMEOUT_CYCLES != 0;
   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                  pwrite_q, pwrite_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  accept, done, tmo;
   // transfer events: command accept, completion on PREADY, abort on wait-state limit
   always_comb begin
      accept = state_q == IDLE && bus.cmd_valid;
      done   = state_q == ACCESS && bus.PREADY;
      tmo    = TEN && state_q == ACCESS && !bus.PREADY && (cnt_q + CW'(1)) == TMAX;
   end
   // next-state: IDLE -> SETUP -> ACCESS -> IDLE, illegal encoding recovers to IDLE
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = accept ? SETUP : IDLE;
         SETUP:   state_d = ACCESS;
         ACCESS:  state_d = (done || tmo) ? IDLE : ACCESS;
         default: state_d = IDLE;
      endcase
   end
   // next values of the registered bus and response outputs
   always_comb begin
      paddr_d       = accept ? bus.cmd_addr : paddr_q;
      pwdata_d      = accept ? bus.cmd_wdata : pwdata_q;
      pwrite_d      = accept ? bus.cmd_write : pwrite_q;
      psel_d        = state_d == SETUP || state_d == ACCESS;
      penable_d     = state_d == ACCESS;
      rsp_valid_d   = done || tmo;
      rsp_err_d     = done ? bus.PSLVERR : tmo ? 1'b1 : rsp_err_q;
      rsp_timeout_d = done ? 1'b0 : tmo ? 1'b1 : rsp_timeout_q;
      rsp_rdata_d   = done ? ((!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : '0) : tmo ? '0 : rsp_rdata_q;
      cnt_d         = state_q == SETUP ? '0 : (state_q == ACCESS && !bus.PREADY) ? cnt_q + CW'(1) : cnt_q;
   end
   // state and output registers with synchronous reset
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pwrite_q      <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_rdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         pwrite_q      <= pwrite_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         rsp_rdata_q   <= rsp_rdata_d;
      end
   end
   assign bus.cmd_ready   = state_q == IDLE;
   assign bus.busy        = state_q == SETUP || state_q == ACCESS;
   assign bus.PADDR       = paddr_q;
   assign bus.PWDATA      = pwdata_q;
   assign bus.PWRITE      = pwrite_q;
   assign bus.PSELx       = psel_q;
   assign bus.PENABLE     = penable_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
endmodule

// File: doc/apb_mac_master.md
Name: apb_mac_master

Overview:
- APB requester (initiator) for the MAC peripheral's APB slave wrapper.
- Converts a simple valid/ready command interface from the system side into APB3 transfers: IDLE -> SETUP -> ACCESS, with wait-state support, PSLVERR capture and a wait-state timeout.
- Returns one response per command.
- Used by test and firmware-model logic to load operands and read back the booth result word at slave offset 255.

Parameters:
- ADDR_WIDTH, 32, width of PADDR and cmd_addr.
- DATA_WIDTH, 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  system/peripheral clock; all state changes on its rising edge.
- PRESET  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept; high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes, errors and timeouts.
- rsp_err  out  1  slave error (PSLVERR) or timeout.
- rsp_timeout  out  1  response ended by timeout.
- busy  out  1  high in SETUP or ACCESS.
- PADDR  out  ADDR_WIDTH  APB address.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PREADY  in  1  APB ready.
- PRDATA  in  DATA_WIDTH  APB read data.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Outputs are registered, except cmd_ready and busy, which decode state_reg.
- Reset (PRESET high at an edge):
  - state goes to IDLE.
  - PSELx, PENABLE, PWRITE, rsp_valid, rsp_err and rsp_timeout go to 0.
  - PADDR, PWDATA and rsp_rdata go to 0.
  - Timeout counter clears.
- Reset mid-transfer: PSELx/PENABLE drop at that edge, no response is produced, and the command is lost.
- States: IDLE, SETUP, ACCESS, encoded 2'b00/2'b01/2'b10. Encoding 2'b11 recovers to IDLE with PSELx/PENABLE low.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid at an edge, latch cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA, set PSELx = 1, PENABLE = 0, and go to SETUP.
- SETUP: always lasts exactly one cycle; set PENABLE = 1 and go to ACCESS.
- ACCESS:
  - PADDR, PWRITE, PWDATA and PSELx are held stable.
  - If PREADY = 1 at an edge, the transfer completes:
    - PSELx and PENABLE go to 0 and the state goes to IDLE.
    - Next cycle: rsp_valid = 1, rsp_err = PSLVERR, rsp_rdata = PRDATA when the transfer was a read and PSLVERR = 0, else 0; rsp_timeout = 0.
  - If PREADY = 0, the timeout counter increments.
  - When TIMEOUT_CYCLES != 0 and the count reaches TIMEOUT_CYCLES with PREADY still 0, abort:
    - PSELx and PENABLE go to 0 and the state goes to IDLE.
    - Next cycle: rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - If PREADY rises in the same cycle the count reaches the limit, completion wins (no timeout).
  - The counter clears on entry to SETUP.
- rsp_valid is high for exactly one cycle and has no backpressure. rsp_err, rsp_timeout and rsp_rdata hold their values until the next response.
- Outside ACCESS, PADDR/PWRITE/PWDATA hold their last values. Only PSELx/PENABLE qualify them.
- A new command can be accepted in the same cycle rsp_valid is high, because the state is already IDLE. The minimum spacing between SETUP phases is therefore 3 cycles with zero wait states.
- Latency, with command accepted at edge E0 and w wait states:
  - SETUP in cycle E0+1.
  - ACCESS from cycle E0+2 through E0+2+w.
  - rsp_valid in cycle E0+3+w.
- Against the MAC slave wrapper, w = 1, so rsp_valid appears at E0+4.
- cmd_valid seen while not in IDLE is ignored (cmd_ready = 0). Command fields are sampled only at the accept edge.

Test Plan:
1. Reset: PRESET high for 2 cycles during ACCESS -> PSELx = PENABLE = 0 the next cycle, state IDLE, cmd_ready = 1, no rsp_valid.
2. Write with 0 wait states: cmd write addr 0x10, data 0x0000_00A5; PREADY tied 1 -> PSELx high for 2 cycles, PENABLE only in the 2nd, PADDR = 0x10 and PWDATA = 0xA5 stable throughout; rsp_valid at E0+3 with rsp_err = 0 and rsp_rdata = 0.
3. Read with 1 wait state against the MAC slave model, mem[255] = 0x0000_3C21 -> rsp_valid at E0+4 with rsp_rdata = 0x0000_3C21 and rsp_err = 0.
4. Error: read addr 0x100 with slave PSLVERR = 1 at completion -> rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0.
5. Timeout: TIMEOUT_CYCLES = 4 and PREADY held 0 -> ACCESS lasts exactly 4 cycles, then PSELx drops; rsp_valid with rsp_err = 1, rsp_timeout = 1. Repeat with PREADY = 1 in the 4th cycle -> normal completion, rsp_timeout = 0.
6. Back-to-back: cmd_valid held high for 3 writes -> each accepted in the IDLE cycle coinciding with the previous rsp_valid; 3 distinct SETUP phases spaced 3 cycles apart; addresses and data match in order.
